// File: rtl/rocketcpu_wb_initiator_if.sv
// Command/response stream and Wishbone classic bus bundle for rocketcpu_wb_initiator.
// master = initiator side, slave = command source, response sink and bus responder.
interface rocketcpu_wb_initiator_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_we;
    logic [31:0] i_cmd_adr;
    logic [31:0] i_cmd_dat;
    logic [3:0]  i_cmd_sel;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_dat;
    logic        o_rsp_err;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack;

    modport master (
        input  i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_rsp_ready,
        input  i_wb_rdt, i_wb_ack,
        output o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err,
        output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );

    modport slave (
        output i_cmd_valid, i_cmd_we, i_cmd_adr, i_cmd_dat, i_cmd_sel, i_rsp_ready,
        output i_wb_rdt, i_wb_ack,
        input  o_cmd_ready, o_rsp_valid, o_rsp_dat, o_rsp_err,
        input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb
    );
endinterface

// File: rtl/rocketcpu_wb_initiator.sv
// Wishbone classic single-transfer initiator; optional ack timeout via WB_INITIATOR_TIMEOUT_EN.
// Latency: bus cycle starts the cycle after command accept, response the cycle after ack/timeout.
// Backpressure: one outstanding transfer; o_cmd_ready stays low until the response is consumed.
module rocketcpu_wb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   i_wb_clk,
    input  logic                   i_wb_rst_n,
    rocketcpu_wb_initiator_if.master bus
);

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("rocketcpu_wb_initiator: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic        timeout_hit;

`ifdef WB_INITIATOR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Firing at TIMEOUT-1 makes the bus cycle last exactly TIMEOUT cycles.
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        wb_sel_d    = wb_sel_q;
        wb_we_d     = wb_we_q;
        wb_cyc_d    = wb_cyc_q;
`ifdef WB_INITIATOR_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_cmd_valid) begin
                    wb_adr_d    = bus.i_cmd_adr;
                    wb_dat_d    = bus.i_cmd_dat;
                    wb_sel_d    = bus.i_cmd_sel;
                    wb_we_d     = bus.i_cmd_we;
                    wb_cyc_d    = 1'b1;
                    cmd_ready_d = 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    state_d     = BUS;
                end
            end
            BUS: begin
                // Ack has priority over a coinciding timeout.
                if (bus.i_wb_ack) begin
                    rsp_dat_d   = wb_we_q ? 32'd0 : bus.i_wb_rdt;
                    rsp_err_d   = 1'b0;
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
`ifdef WB_INITIATOR_TIMEOUT_EN
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                wb_cyc_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            wb_adr_q    <= 32'd0;
            wb_dat_q    <= 32'd0;
            wb_sel_q    <= 4'd0;
            wb_we_q     <= 1'b0;
            wb_cyc_q    <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            wb_sel_q    <= wb_sel_d;
            wb_we_q     <= wb_we_d;
            wb_cyc_q    <= wb_cyc_d;
`ifdef WB_INITIATOR_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.o_cmd_ready = cmd_ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_dat   = rsp_dat_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_wb_adr    = wb_adr_q;
    assign bus.o_wb_dat    = wb_dat_q;
    assign bus.o_wb_sel    = wb_sel_q;
    assign bus.o_wb_we     = wb_we_q;
    assign bus.o_wb_cyc    = wb_cyc_q;
    assign bus.o_wb_stb    = wb_cyc_q;

endmodule
